// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field layout, fetch FSM encoding.
// Pure declarations; no timing or flow control of its own.
package sisc_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 16;
   localparam int OPC_W   = 4;
   localparam int TMO_W   = 4;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam int MM_MSB  = 27;
   localparam int MM_LSB  = 24;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   localparam logic [OPC_W-1:0] NOOP   = 4'd0;
   localparam logic [OPC_W-1:0] LOD    = 4'd1;
   localparam logic [OPC_W-1:0] STR    = 4'd2;
   localparam logic [OPC_W-1:0] BRA    = 4'd4;
   localparam logic [OPC_W-1:0] BRR    = 4'd5;
   localparam logic [OPC_W-1:0] BNE    = 4'd6;
   localparam logic [OPC_W-1:0] ALU_OP = 4'd8;
   localparam logic [OPC_W-1:0] HLT    = 4'd15;

   localparam logic [3:0] AM_IMM = 4'd8;

   // Cycles spent in WAIT without an ack before the fetch is declared dead.
   localparam int FETCH_TIMEOUT = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } fetch_state_t;

   // Field order matches the bit positions above.
   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [3:0]       mm;
      logic [7:0]       rsvd;
      logic [15:0]      imm;
   } instr_t;

   function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
      return w[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic is_halt(input logic [INSTR_W-1:0] w);
      return instr_opcode(w) == HLT;
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with +1 / relative / absolute next-PC selection, mod 2^16.
// Updates on the clock edge when enabled; synchronous clear has priority; no backpressure.
module pc_unit
   import sisc_pkg::*;
(
   input  logic            clk,
   input  logic            rst_f,
   input  logic            pc_rst,
   input  logic            pc_write,
   input  logic            pc_sel,
   input  logic            br_sel,
   input  logic [PC_W-1:0] imm,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_rel;
   logic [PC_W-1:0] pc_tgt;
   logic [PC_W-1:0] pc_nxt;

   // Relative offsets are two's complement; plain 16-bit wraparound handles both directions.
   always_comb begin
      pc_inc = pc_q + PC_W'(1);
      pc_rel = pc_q + imm;
      pc_tgt = br_sel ? imm : pc_rel;
      pc_nxt = pc_sel ? pc_tgt : pc_inc;
   end

   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         pc_q <= '0;
      end else if (pc_rst) begin
         pc_q <= '0;
      end else if (pc_write) begin
         pc_q <= pc_nxt;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, fetch FSM with timeout, IR, halt, status and instruction count.
// IR loads on the ack edge (ir_valid one cycle later); ir_load is ignored while busy or halted.
module instr_fetch
   import sisc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_f,
   input  logic               pc_rst,
   input  logic               pc_write,
   input  logic               pc_sel,
   input  logic               br_sel,
   input  logic               ir_load,
   input  logic               stat_we,
   input  logic [3:0]         stat_in,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] ir,
   output logic [OPC_W-1:0]   opcode,
   output logic [3:0]         mm,
   output logic [3:0]         stat,
   output logic [PC_W-1:0]    pc,
   output logic               ir_valid,
   output logic               ir_busy,
   output logic               halted,
   output logic               fetch_err,
   output logic [15:0]        instr_cnt
);

   fetch_state_t     state_q;
   fetch_state_t     state_nxt;
   logic [TMO_W-1:0] tmo_q;
   instr_t           ir_q;
   logic             start_fetch;
   logic             load_ir;
   logic             fetch_tmo;

   pc_unit u_pc (
      .clk      (clk),
      .rst_f    (rst_f),
      .pc_rst   (pc_rst),
      .pc_write (pc_write),
      .pc_sel   (pc_sel),
      .br_sel   (br_sel),
      .imm      (ir_q.imm),
      .pc       (pc)
   );

   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Ack only counts in WAIT, so a stray ack in IDLE/ERR or after a reset is dropped here.
   always_comb begin
      state_nxt   = state_q;
      start_fetch = 1'b0;
      load_ir     = 1'b0;
      fetch_tmo   = 1'b0;
      ir_busy     = 1'b1;
      case (state_q)
         IDLE: begin
            ir_busy = 1'b0;
            if (ir_load && !halted) begin
               start_fetch = 1'b1;
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               load_ir   = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_q == TMO_W'(FETCH_TIMEOUT - 1)) begin
               fetch_tmo = 1'b1;
               state_nxt = ERR;
            end
         end
         ERR: begin
            state_nxt = ERR;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Address is captured at fetch start so PC updates during WAIT do not disturb it.
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else if (start_fetch) begin
         imem_req  <= 1'b1;
         imem_addr <= pc;
      end else if (load_ir || fetch_tmo) begin
         imem_req  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         tmo_q <= '0;
      end else if (start_fetch) begin
         tmo_q <= '0;
      end else if (state_q == WAIT && !imem_ack && !fetch_tmo) begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         ir_q      <= '0;
         ir_valid  <= 1'b0;
         halted    <= 1'b0;
         instr_cnt <= '0;
      end else begin
         ir_valid <= load_ir;
         if (load_ir) begin
            ir_q <= instr_t'(imem_rdata);
            if (is_halt(imem_rdata)) begin
               halted <= 1'b1;
            end
            if (instr_cnt != 16'hFFFF) begin
               instr_cnt <= instr_cnt + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         fetch_err <= 1'b0;
      end else if (fetch_tmo) begin
         fetch_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         stat <= '0;
      end else if (stat_we) begin
         stat <= stat_in;
      end
   end

   assign ir     = ir_q;
   assign opcode = ir_q.opcode;
   assign mm     = ir_q.mm;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch addresses and IR words go through a scoreboard queue.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_f = 1'b1;
   logic        pc_rst = 1'b0;
   logic        pc_write = 1'b0;
   logic        pc_sel = 1'b0;
   logic        br_sel = 1'b0;
   logic        ir_load = 1'b0;
   logic        stat_we = 1'b0;
   logic [3:0]  stat_in = 4'h0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] ir;
   logic [3:0]  opcode;
   logic [3:0]  mm;
   logic [3:0]  stat;
   logic [15:0] pc;
   logic        ir_valid;
   logic        ir_busy;
   logic        halted;
   logic        fetch_err;
   logic [15:0] instr_cnt;

   int checks = 0;
   int errors = 0;
   int cnt_exp = 0;
   logic [31:0] exp_ir_q[$];
   logic [15:0] exp_addr_q[$];

   instr_fetch dut (
      .clk        (clk),
      .rst_f      (rst_f),
      .pc_rst     (pc_rst),
      .pc_write   (pc_write),
      .pc_sel     (pc_sel),
      .br_sel     (br_sel),
      .ir_load    (ir_load),
      .stat_we    (stat_we),
      .stat_in    (stat_in),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .ir         (ir),
      .opcode     (opcode),
      .mm         (mm),
      .stat       (stat),
      .pc         (pc),
      .ir_valid   (ir_valid),
      .ir_busy    (ir_busy),
      .halted     (halted),
      .fetch_err  (fetch_err),
      .instr_cnt  (instr_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete fetch; ack is driven on the (lat+1)-th edge after fetch start.
   task automatic fetch(input logic [31:0] rdata, input logic [15:0] addr, input int lat,
                        input string tag, input logic do_stat);
      logic [15:0] ea;
      logic [31:0] ei;
      int n;
      exp_addr_q.push_back(addr);
      exp_ir_q.push_back(rdata);
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      ea = exp_addr_q.pop_front();
      chk({tag, ".req"}, {31'b0, imem_req}, 32'd1);
      chk({tag, ".addr"}, {16'b0, imem_addr}, {16'b0, ea});
      chk({tag, ".busy"}, {31'b0, ir_busy}, 32'd1);
      repeat (lat) tick();
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      if (do_stat) begin
         stat_we = 1'b1;
         stat_in = 4'hA;
      end
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      stat_we    = 1'b0;
      stat_in    = 4'h0;
      n = 0;
      while (!ir_valid && n < 4) begin
         tick();
         n++;
      end
      chk({tag, ".valid"}, {31'b0, ir_valid}, 32'd1);
      ei = exp_ir_q.pop_front();
      cnt_exp++;
      chk({tag, ".ir"}, ir, ei);
      chk({tag, ".opcode"}, {28'b0, opcode}, {28'b0, ei[31:28]});
      chk({tag, ".mm"}, {28'b0, mm}, {28'b0, ei[27:24]});
      chk({tag, ".cnt"}, {16'b0, instr_cnt}, cnt_exp);
      chk({tag, ".req_drop"}, {31'b0, imem_req}, 32'd0);
      if (do_stat) chk({tag, ".stat"}, {28'b0, stat}, 32'hA);
      tick();
      chk({tag, ".pulse"}, {31'b0, ir_valid}, 32'd0);
   endtask

   task automatic do_reset();
      rst_f = 1'b1;
      tick();
      rst_f = 1'b0;
      cnt_exp = 0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst.pc", {16'b0, pc}, 32'd0);
      chk("rst.ir", ir, 32'd0);
      chk("rst.req", {31'b0, imem_req}, 32'd0);
      chk("rst.addr", {16'b0, imem_addr}, 32'd0);
      chk("rst.cnt", {16'b0, instr_cnt}, 32'd0);
      chk("rst.halted", {31'b0, halted}, 32'd0);
      chk("rst.err", {31'b0, fetch_err}, 32'd0);
      chk("rst.busy", {31'b0, ir_busy}, 32'd0);
      chk("rst.valid", {31'b0, ir_valid}, 32'd0);
      rst_f = 1'b0;
      tick();

      fetch(32'h8100_0005, 16'h0000, 1, "basic", 1'b0);

      pc_write = 1'b1;
      repeat (16) tick();
      pc_write = 1'b0;
      chk("pc.inc16", {16'b0, pc}, 32'h0010);
      fetch(32'h0000_FFFE, 16'h0010, 0, "imm", 1'b0);

      pc_write = 1'b1;
      pc_sel   = 1'b1;
      br_sel   = 1'b0;
      tick();
      chk("pc.rel", {16'b0, pc}, 32'h000E);
      br_sel = 1'b1;
      tick();
      chk("pc.abs", {16'b0, pc}, 32'hFFFE);
      pc_sel = 1'b0;
      tick();
      chk("pc.ffff", {16'b0, pc}, 32'hFFFF);
      tick();
      chk("pc.wrap", {16'b0, pc}, 32'h0000);
      tick();
      chk("pc.one", {16'b0, pc}, 32'h0001);
      pc_rst = 1'b1;
      tick();
      chk("pc.rst_prio", {16'b0, pc}, 32'h0000);
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      br_sel   = 1'b0;

      fetch(32'h2000_0003, 16'h0000, 2, "stat", 1'b1);

      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack   = 1'b0;
      chk("idle_ack.valid", {31'b0, ir_valid}, 32'd0);
      chk("idle_ack.ir", ir, 32'h2000_0003);
      chk("idle_ack.cnt", {16'b0, instr_cnt}, cnt_exp);

      fetch(32'h1000_0007, 16'h0000, 14, "ack15", 1'b0);
      chk("ack15.err", {31'b0, fetch_err}, 32'd0);

      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      repeat (14) tick();
      chk("tmo.req14", {31'b0, imem_req}, 32'd1);
      chk("tmo.err14", {31'b0, fetch_err}, 32'd0);
      tick();
      chk("tmo.err", {31'b0, fetch_err}, 32'd1);
      chk("tmo.req", {31'b0, imem_req}, 32'd0);
      chk("tmo.busy", {31'b0, ir_busy}, 32'd1);
      ir_load    = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h3333_3333;
      repeat (3) tick();
      ir_load  = 1'b0;
      imem_ack = 1'b0;
      chk("err.req", {31'b0, imem_req}, 32'd0);
      chk("err.valid", {31'b0, ir_valid}, 32'd0);
      chk("err.ir", ir, 32'h1000_0007);
      chk("err.cnt", {16'b0, instr_cnt}, cnt_exp);
      chk("err.sticky", {31'b0, fetch_err}, 32'd1);

      do_reset();
      chk("rst2.err", {31'b0, fetch_err}, 32'd0);
      chk("rst2.busy", {31'b0, ir_busy}, 32'd0);
      chk("rst2.cnt", {16'b0, instr_cnt}, 32'd0);

      fetch(32'hF000_0000, 16'h0000, 1, "hlt", 1'b0);
      chk("hlt.halted", {31'b0, halted}, 32'd1);
      chk("hlt.opcode", {28'b0, opcode}, 32'd15);
      ir_load = 1'b1;
      tick();
      chk("hlt.noreq", {31'b0, imem_req}, 32'd0);
      tick();
      chk("hlt.noreq2", {31'b0, imem_req}, 32'd0);
      chk("hlt.idle", {31'b0, ir_busy}, 32'd0);
      ir_load = 1'b0;

      do_reset();
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      chk("abort.req", {31'b0, imem_req}, 32'd1);
      rst_f = 1'b1;
      tick();
      rst_f = 1'b0;
      chk("abort.req_rst", {31'b0, imem_req}, 32'd0);
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'h8100_0005;
      tick();
      imem_ack = 1'b0;
      tick();
      chk("abort.ir", ir, 32'd0);
      chk("abort.cnt", {16'b0, instr_cnt}, 32'd0);
      chk("abort.req_late", {31'b0, imem_req}, 32'd0);
      chk("abort.valid", {31'b0, ir_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk input 1: system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_f input 1: asynchronous reset, active-high (1 = reset).
REQ-003 SHALL have port pc_rst input 1: synchronous PC clear from the controller.
REQ-004 SHALL have port pc_write input 1: PC update enable.
REQ-005 SHALL have port pc_sel input 1: next-PC select; 0 = PC+1, 1 = branch target.
REQ-006 SHALL have port br_sel input 1: branch target select; 0 = relative (PC+imm), 1 = absolute (imm).
REQ-007 SHALL have port ir_load input 1: start instruction fetch at current PC.
REQ-008 SHALL have port stat_we input 1: load status register.
REQ-009 SHALL have port stat_in input 4: ALU status flags.
REQ-010 SHALL have port imem_req output 1: memory read request.
REQ-011 SHALL have port imem_addr output 16: memory read address.
REQ-012 SHALL have port imem_ack input 1: read data valid this cycle.
REQ-013 SHALL have port imem_rdata input 32: instruction word.
REQ-014 SHALL have port ir output 32: instruction register.
REQ-015 SHALL have ports opcode output 4 (ir[31:28]), mm output 4 (ir[27:24]), stat output 4 (status register).
REQ-016 SHALL have ports pc output 16, ir_valid output 1 (one-cycle load pulse), ir_busy output 1, halted output 1, fetch_err output 1, instr_cnt output 16.

Function
REQ-017 PC: pc_rst=1 -> PC<=0 (priority); else pc_write=1 -> PC<=next-PC; else hold.
REQ-018 Next-PC: pc_sel=0 -> PC+1; pc_sel=1 -> br_sel ? ir[15:0] : PC+ir[15:0]; all 16-bit modulo-2^16 (0xFFFF+1 = 0x0000; relative offset two's complement).
REQ-019 Fetch FSM states IDLE, WAIT, ERR.
REQ-020 IDLE: ir_busy=0; ir_load=1 and halted=0 -> imem_addr<=PC, imem_req<=1, timeout counter<=0, go WAIT.
REQ-021 WAIT: ir_busy=1, imem_req and imem_addr held stable; imem_ack=1 -> ir<=imem_rdata, ir_valid=1 next cycle for exactly one cycle, imem_req<=0, go IDLE.
REQ-022 WAIT: ir_load ignored; PC updates (REQ-017) still permitted, fetch address unaffected.
REQ-023 WAIT: 15 consecutive cycles without imem_ack -> imem_req<=0, fetch_err<=1, go ERR; ack in 15th cycle wins over timeout.
REQ-024 ERR: terminal until reset; ir_busy=1, ir_load ignored, fetch_err sticky.
REQ-025 imem_ack while IDLE or ERR SHALL be ignored.
REQ-026 Halt: IR loaded with opcode HLT (15) -> halted<=1 same edge as ir load; sticky; subsequent ir_load ignored.
REQ-027 Status register: stat_we=1 -> stat<=stat_in; otherwise hold; independent of FSM state.
REQ-028 instr_cnt increments on every IR load, saturates at 0xFFFF.
REQ-029 opcode and mm SHALL be combinational slices of ir, no extra latency.

Reset
REQ-030 rst_f=1 SHALL asynchronously force: PC=0, ir=0 (opcode NOOP), stat=0, imem_req=0, imem_addr=0, ir_valid=0, halted=0, fetch_err=0, instr_cnt=0, FSM=IDLE, timeout counter=0.
REQ-031 Reset during WAIT SHALL abandon the fetch; a late imem_ack after reset release is ignored per REQ-025.

Structure
REQ-032 Shared package sisc_pkg SHALL hold opcode constants (NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, ALU_OP=8, HLT=15), am_imm=8, instruction field positions, FETCH_TIMEOUT=15, fetch FSM state encoding.
REQ-033 Sub-module pc_unit SHALL contain PC register, adder and next-PC mux; FSM, IR, status, counter remain in instr_fetch.

Verification
REQ-034 Reset release, ir_load pulse, ack after 2 cycles with rdata 0x8100_0005 -> imem_addr=0x0000, ir=0x8100_0005, opcode=8, mm=1, ir_valid one cycle, instr_cnt=1.
REQ-035 PC=0x0010, ir[15:0]=0xFFFE, pc_sel=1, br_sel=0, pc_write=1 -> PC=0x000E; br_sel=1 -> PC=0xFFFE; then pc_sel=0 -> PC=0xFFFF, again -> 0x0000.
REQ-036 ir_load, no ack for 15 cycles -> fetch_err=1, imem_req=0, FSM ERR; later ir_load and ack ignored until rst_f.
REQ-037 Fetch rdata 0xF000_0000 -> halted=1, opcode=15; next ir_load produces no imem_req.
REQ-038 rst_f asserted mid-WAIT, ack arrives 1 cycle after release -> ir stays 0, instr_cnt stays 0, imem_req=0.
REQ-039 stat_we=1 with stat_in=0xA concurrent with ack -> stat=0xA and ir loaded same edge; pc_rst and pc_write both 1 -> PC=0.
